// File: rtl/wb_regfile.sv
// Writeback register file with a busy-bit issue scoreboard and registered reads.
// Optional write-to-read forwarding is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int NREGS = 128,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Rdout,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             Wrenable,
  input  logic [6:0]       Rs1,
  input  logic [6:0]       Rs2,
  input  logic             IssueValid,
  input  logic [6:0]       IssueRd,
  output logic [WIDTH-1:0] RdData1,
  output logic [WIDTH-1:0] RdData2,
  output logic             Stall,
  output logic [7:0]       PendCnt
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic             wb_hit;
  logic             set_hit;
  logic             inc;
  logic             dec;
  logic             busy_rs1;
  logic             busy_rs2;
  logic             busy_rd;
  logic [WIDTH-1:0] rd1_next;
  logic [WIDTH-1:0] rd2_next;

  always_comb begin
    wb_hit = Wrenable && (Rdout != 7'd0);
`ifdef WB_REGFILE_BYPASS_EN
    // A register retiring this cycle no longer blocks issue and forwards its data.
    busy_rs1 = busy[Rs1]     && !(wb_hit && (Rdout == Rs1));
    busy_rs2 = busy[Rs2]     && !(wb_hit && (Rdout == Rs2));
    busy_rd  = busy[IssueRd] && !(wb_hit && (Rdout == IssueRd));
    rd1_next = (wb_hit && (Rdout == Rs1)) ? AluResult : regs[Rs1];
    rd2_next = (wb_hit && (Rdout == Rs2)) ? AluResult : regs[Rs2];
`else
    busy_rs1 = busy[Rs1];
    busy_rs2 = busy[Rs2];
    busy_rd  = busy[IssueRd];
    rd1_next = regs[Rs1];
    rd2_next = regs[Rs2];
`endif
    Stall   = IssueValid && (busy_rs1 || busy_rs2 || busy_rd);
    set_hit = IssueValid && !Stall && (IssueRd != 7'd0);
    // Count follows actual bit transitions so it always equals the popcount.
    inc     = set_hit && !busy[IssueRd];
    dec     = wb_hit && busy[Rdout] && !(set_hit && (IssueRd == Rdout));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[Rdout] <= AluResult;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RdData1 <= '0;
      RdData2 <= '0;
    end else begin
      RdData1 <= rd1_next;
      RdData2 <= rd2_next;
    end
  end

  // Set is applied after clear so a same-index set/clear leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_hit) begin
        busy[Rdout] <= 1'b0;
      end
      if (set_hit) begin
        busy[IssueRd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PendCnt <= 8'd0;
    end else begin
      case ({inc, dec})
        2'b10: if (PendCnt != 8'(NREGS - 1)) PendCnt <= PendCnt + 8'd1;
        2'b01: if (PendCnt != 8'd0)          PendCnt <= PendCnt - 8'd1;
        default: PendCnt <= PendCnt;
      endcase
    end
  end

endmodule
